// File: rtl/yl3_pkg.sv
// Shared YL-3 constants plus the segment-to-ASCII table that the driver's character encoder also uses.
package yl3_pkg;

    localparam int YL3_FRAME_BITS = 16;
    localparam int YL3_DIGITS     = 8;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DP    = 8'h7F;
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h98;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_H     = 8'h89;
    localparam logic [7:0] SEG_L     = 8'hC7;
    localparam logic [7:0] SEG_N     = 8'hAB;
    localparam logic [7:0] SEG_P     = 8'h8C;
    localparam logic [7:0] SEG_U     = 8'hC1;

    function automatic logic is_one_hot8(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

    function automatic logic [7:0] yl3_seg_to_ascii(input logic [7:0] seg);
        logic [7:0] ch;
        case (seg)
            SEG_0:     ch = 8'h30;
            SEG_1:     ch = 8'h31;
            SEG_2:     ch = 8'h32;
            SEG_3:     ch = 8'h33;
            SEG_4:     ch = 8'h34;
            SEG_5:     ch = 8'h35;
            SEG_6:     ch = 8'h36;
            SEG_7:     ch = 8'h37;
            SEG_8:     ch = 8'h38;
            SEG_9:     ch = 8'h39;
            SEG_A:     ch = 8'h41;
            SEG_B:     ch = 8'h62;
            SEG_C:     ch = 8'h43;
            SEG_D:     ch = 8'h64;
            SEG_E:     ch = 8'h45;
            SEG_F:     ch = 8'h46;
            SEG_H:     ch = 8'h48;
            SEG_L:     ch = 8'h4C;
            SEG_N:     ch = 8'h6E;
            SEG_P:     ch = 8'h50;
            SEG_U:     ch = 8'h55;
            SEG_DP:    ch = 8'h2E;
            SEG_BLANK: ch = 8'h20;
            default:   ch = 8'h3F;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/yl3_seg_decode.sv
// Combinational active-low .GFEDCBA segment byte to ASCII character decoder.
module yl3_seg_decode
    import yl3_pkg::*;
(
    input  logic [7:0] seg_i,
    output logic [7:0] ascii_o
);

    // Table lookup shared with the driver's encoder
    always_comb begin
        ascii_o = yl3_seg_to_ascii(seg_i);
    end

endmodule

// File: rtl/yl3_display_rx.sv
// YL-3 serial link receiver: synchronizes DIO/SCK/RCK, deserializes {position, segments} frames, keeps the digit image.
// Optional ASCII image on CHARS when YL3_ASCII_DECODE_EN is defined.
module yl3_display_rx
    import yl3_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = YL3_FRAME_BITS,
    parameter int DIGITS      = YL3_DIGITS
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                DIO,
    input  logic                SCK,
    input  logic                RCK,
    output logic [DIGITS*8-1:0] SEGS,
    output logic                UPDATED,
    output logic                POS_ERR,
    output logic                BIT_ERR
`ifdef YL3_ASCII_DECODE_EN
    ,
    output logic [DIGITS*8-1:0] CHARS
`endif
);

    logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
    logic [2:0]                  prev_q, prev_d;
    logic [2:0]                  pins_s, rise_s;
    logic [FRAME_BITS-1:0]       shreg_q, shreg_d;
    logic [4:0]                  bitcnt_q, bitcnt_d;
    logic [DIGITS*8-1:0]         segs_q, segs_d;
    logic                        updated_q, updated_d;
    logic                        pos_err_q, pos_err_d;
    logic                        bit_err_q, bit_err_d;
    logic [DIGITS-1:0]           pos_s;
    logic [7:0]                  seg_s;

    assign pins_s = {RCK, SCK, DIO};

    // Synchronizer chain; a rise is the newest synchronized level high while the delayed copy is low
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pins_s};
        prev_d = sync_q[SYNC_STAGES-1];
        rise_s = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    // Shift, count and latch datapath; the latch reads the pre-shift register like a 74HC595
    always_comb begin
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        segs_d    = segs_q;
        updated_d = 1'b0;
        pos_err_d = 1'b0;
        bit_err_d = 1'b0;
        pos_s     = shreg_q[FRAME_BITS-1 -: DIGITS];
        seg_s     = shreg_q[7:0];
        if (rise_s[1]) begin
            shreg_d  = {shreg_q[FRAME_BITS-2:0], sync_q[SYNC_STAGES-1][0]};
            bitcnt_d = (bitcnt_q == 5'd31) ? 5'd31 : bitcnt_q + 5'd1;
        end else begin
            shreg_d  = shreg_q;
        end
        if (rise_s[2]) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (pos_s[i]) begin
                    segs_d[(DIGITS-1-i)*8 +: 8] = seg_s;
                end else begin
                    segs_d[(DIGITS-1-i)*8 +: 8] = segs_q[(DIGITS-1-i)*8 +: 8];
                end
            end
            updated_d = |pos_s;
            pos_err_d = ~is_one_hot8(pos_s);
            bit_err_d = (bitcnt_q != 5'(FRAME_BITS));
            bitcnt_d  = rise_s[1] ? 5'd1 : 5'd0;
        end else begin
            updated_d = 1'b0;
        end
    end

    // State and registered outputs
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync_q    <= '0;
            prev_q    <= 3'b000;
            shreg_q   <= '0;
            bitcnt_q  <= 5'd0;
            segs_q    <= {DIGITS{SEG_BLANK}};
            updated_q <= 1'b0;
            pos_err_q <= 1'b0;
            bit_err_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            segs_q    <= segs_d;
            updated_q <= updated_d;
            pos_err_q <= pos_err_d;
            bit_err_q <= bit_err_d;
        end
    end

    assign SEGS    = segs_q;
    assign UPDATED = updated_q;
    assign POS_ERR = pos_err_q;
    assign BIT_ERR = bit_err_q;

`ifdef YL3_ASCII_DECODE_EN
    logic [DIGITS*8-1:0] chars_q, chars_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        yl3_seg_decode u_dec (
            .seg_i   (segs_d[(DIGITS-1-g)*8 +: 8]),
            .ascii_o (chars_d[(DIGITS-1-g)*8 +: 8])
        );
    end

    // Character image registered alongside the segment image
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            chars_q <= {DIGITS{8'h20}};
        end else begin
            chars_q <= chars_d;
        end
    end

    assign CHARS = chars_q;
`endif

endmodule
